// File: rtl/np_cpl_pkg.sv
// Shared types and helpers for the non-posted completion request queue.
//  - cpl_hdr_t : TLP header part of a queued descriptor (MSB first)
//  - desc_w()  : full descriptor width for a given address width
//  - pack_hdr(): assembles the header part from individual request fields
//  - pop_state_t: pop FSM encoding
// A full descriptor is {cpl_hdr_t, addr[ADDR_W-1:0]}.
package np_cpl_pkg;

    localparam int unsigned HDR_W = 50;

    // Field offsets within the header part (addr occupies the bits below it).
    typedef struct packed {
        logic        with_data;   // bit 49
        logic [2:0]  tc;          // bits 48:46
        logic        td;          // bit 45
        logic        ep;          // bit 44
        logic [1:0]  attr;        // bits 43:42
        logic [9:0]  len;         // bits 41:32
        logic [15:0] rid;         // bits 31:16
        logic [7:0]  tag;         // bits 15:8
        logic [7:0]  be;          // bits 7:0
    } cpl_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2
    } pop_state_t;

    function automatic int unsigned desc_w(input int unsigned addr_w);
        return HDR_W + addr_w;
    endfunction

    function automatic cpl_hdr_t pack_hdr(
        input logic        with_data,
        input logic [2:0]  tc,
        input logic        td,
        input logic        ep,
        input logic [1:0]  attr,
        input logic [9:0]  len,
        input logic [15:0] rid,
        input logic [7:0]  tag,
        input logic [7:0]  be
    );
        cpl_hdr_t h;
        h.with_data = with_data;
        h.tc        = tc;
        h.td        = td;
        h.ep        = ep;
        h.attr      = attr;
        h.len       = len;
        h.rid       = rid;
        h.tag       = tag;
        h.be        = be;
        return h;
    endfunction

endpackage

// File: rtl/np_cpl_queue_sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x WIDTH single-clock FIFO with registered read data.
//  i_wr_en/i_wr_data : write request (ignored when full or flushing)
//  i_rd_en           : pop; o_rd_data is valid the cycle after
//  i_flush           : clears pointers and count on the next edge
//  o_count           : registered occupancy
//  o_next_count_c    : occupancy after the coming edge
//  o_full_c/o_empty_c: derived from the registered occupancy
module sync_fifo_ram #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 63,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_next_count_c,
    output logic             o_full_c,
    output logic             o_empty_c
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr_fire;
    logic             w_rd_fire;

    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);

    // Fullness is judged on the pre-edge count: a same-cycle pop frees nothing.
    assign w_wr_fire = i_wr_en && !o_full_c && !i_flush;
    assign w_rd_fire = i_rd_en && !o_empty_c && !i_flush;

    // Occupancy after the coming edge.
    always_comb begin
        o_next_count_c = r_count;
        if (i_flush) begin
            o_next_count_c = '0;
        end else if (w_wr_fire && !w_rd_fire) begin
            o_next_count_c = r_count + CNT_W'(1);
        end else if (!w_wr_fire && w_rd_fire) begin
            o_next_count_c = r_count - CNT_W'(1);
        end
    end

    // Pointer and count registers; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= o_next_count_c;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_fire) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_rd_fire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage array and registered read port.
    always_ff @(posedge clk) begin
        if (w_wr_fire) r_mem[r_wr_ptr] <= i_wr_data;
        if (w_rd_fire) r_rd_data <= r_mem[r_rd_ptr];
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;

endmodule

// File: rtl/np_cpl_queue.sv
// np_cpl_queue: non-posted completion request queue between RX and TX engines.
// Requests are stored as packed descriptors and issued one at a time, in order,
// over a level (req_compl_o) / done (compl_done_i) handshake.
//  clk, rst (async, active high)
//  req_compl_i + req_*_i : enqueue one descriptor
//  flush_i               : discard all queued (not yet loaded) entries
//  rx_np_ok_o            : RX may accept non-posted TLPs (headroom throttle)
//  req_compl_o + req_*_o : current request to TX, held until retired
//  compl_done_i/_o       : TX done in / retire pulse out
//  count_o               : queued entries, excluding the one being issued
//  ovf_o, timeout_o      : sticky error flags
module np_cpl_queue
    import np_cpl_pkg::*;
#(
    parameter  int unsigned DEPTH       = 16,
    parameter  int unsigned ADDR_W      = 13,
    parameter  int unsigned NP_HEADROOM = 2,
    parameter  int unsigned TIMEOUT_CYC = 0,
    localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_compl_i,
    input  logic              req_compl_with_data_i,
    input  logic [2:0]        req_tc_i,
    input  logic              req_td_i,
    input  logic              req_ep_i,
    input  logic [1:0]        req_attr_i,
    input  logic [9:0]        req_len_i,
    input  logic [15:0]       req_rid_i,
    input  logic [7:0]        req_tag_i,
    input  logic [7:0]        req_be_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              flush_i,
    output logic              rx_np_ok_o,
    output logic              req_compl_o,
    output logic              req_compl_with_data_o,
    output logic [2:0]        req_tc_o,
    output logic              req_td_o,
    output logic              req_ep_o,
    output logic [1:0]        req_attr_o,
    output logic [9:0]        req_len_o,
    output logic [15:0]       req_rid_o,
    output logic [7:0]        req_tag_o,
    output logic [7:0]        req_be_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              compl_done_i,
    output logic              compl_done_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              ovf_o,
    output logic              timeout_o
);

    localparam int unsigned DESC_W = desc_w(ADDR_W);
    localparam int unsigned TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    pop_state_t        r_state;
    logic [TMR_W-1:0]  r_timer;

    logic [DESC_W-1:0] w_wr_desc;
    logic [DESC_W-1:0] w_rd_desc;
    cpl_hdr_t          w_rd_hdr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [CNT_W-1:0]  w_next_count;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_timeout_hit;
    logic              w_np_ok;

    assign w_wr_desc = {pack_hdr(req_compl_with_data_i, req_tc_i, req_td_i, req_ep_i,
                                 req_attr_i, req_len_i, req_rid_i, req_tag_i, req_be_i),
                        req_addr_i};

    assign w_rd_hdr  = w_rd_desc[DESC_W-1 -: HDR_W];
    assign w_rd_addr = w_rd_desc[ADDR_W-1:0];

    // A pop is only taken from IDLE, and never in a flush cycle.
    assign w_pop = (r_state == ST_IDLE) && !w_empty && !flush_i;

    assign w_timeout_hit = (TIMEOUT_CYC != 0) && (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    // Throttle RX while the free space would be at or below the headroom.
    assign w_np_ok = (CNT_W'(DEPTH) - w_next_count) > CNT_W'(NP_HEADROOM);

    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DESC_W)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (flush_i),
        .i_wr_en        (req_compl_i),
        .i_wr_data      (w_wr_desc),
        .i_rd_en        (w_pop),
        .o_rd_data      (w_rd_desc),
        .o_count        (count_o),
        .o_next_count_c (w_next_count),
        .o_full_c       (w_full),
        .o_empty_c      (w_empty)
    );

    // Pop FSM, issue timer, descriptor output registers and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state               <= ST_IDLE;
            r_timer               <= '0;
            req_compl_o           <= 1'b0;
            req_compl_with_data_o <= 1'b0;
            req_tc_o              <= '0;
            req_td_o              <= 1'b0;
            req_ep_o              <= 1'b0;
            req_attr_o            <= '0;
            req_len_o             <= '0;
            req_rid_o             <= '0;
            req_tag_o             <= '0;
            req_be_o              <= '0;
            req_addr_o            <= '0;
            compl_done_o          <= 1'b0;
            rx_np_ok_o            <= 1'b1;
            ovf_o                 <= 1'b0;
            timeout_o             <= 1'b0;
        end else begin
            compl_done_o <= 1'b0;
            rx_np_ok_o   <= w_np_ok;

            // Enqueues coinciding with a flush are discarded silently.
            if (req_compl_i && w_full && !flush_i) begin
                ovf_o <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    req_compl_with_data_o <= w_rd_hdr.with_data;
                    req_tc_o              <= w_rd_hdr.tc;
                    req_td_o              <= w_rd_hdr.td;
                    req_ep_o              <= w_rd_hdr.ep;
                    req_attr_o            <= w_rd_hdr.attr;
                    req_len_o             <= w_rd_hdr.len;
                    req_rid_o             <= w_rd_hdr.rid;
                    req_tag_o             <= w_rd_hdr.tag;
                    req_be_o              <= w_rd_hdr.be;
                    req_addr_o            <= w_rd_addr;
                    req_compl_o           <= 1'b1;
                    r_timer               <= '0;
                    r_state               <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // A real done wins over a coincident timeout.
                    if (compl_done_i || w_timeout_hit) begin
                        req_compl_o  <= 1'b0;
                        compl_done_o <= 1'b1;
                        if (!compl_done_i) begin
                            timeout_o <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_np_cpl_queue.sv
// Directed bench for np_cpl_queue. Two instances share stimulus: u_dut uses
// the default parameters (no timeout), u_dut_to uses TIMEOUT_CYC=8.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_np_cpl_queue;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned CNT_W  = 5;

    logic              clk;
    logic              rst;
    logic              req_compl_i;
    logic              req_compl_with_data_i;
    logic [2:0]        req_tc_i;
    logic              req_td_i;
    logic              req_ep_i;
    logic [1:0]        req_attr_i;
    logic [9:0]        req_len_i;
    logic [15:0]       req_rid_i;
    logic [7:0]        req_tag_i;
    logic [7:0]        req_be_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic              flush_i;
    logic              compl_done_i;

    logic              rx_np_ok, req_compl, wd, td, ep, compl_done, ovf, tmo;
    logic [2:0]        tc;
    logic [1:0]        attr;
    logic [9:0]        len;
    logic [15:0]       rid;
    logic [7:0]        tag, be;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;

    logic              to_rx_np_ok, to_req_compl, to_wd, to_td, to_ep, to_compl_done, to_ovf, to_tmo;
    logic [2:0]        to_tc;
    logic [1:0]        to_attr;
    logic [9:0]        to_len;
    logic [15:0]       to_rid;
    logic [7:0]        to_tag, to_be;
    logic [ADDR_W-1:0] to_addr;
    logic [CNT_W-1:0]  to_count;

    int n_checks = 0;
    int n_errors = 0;

    np_cpl_queue u_dut (
        .clk(clk), .rst(rst),
        .req_compl_i(req_compl_i), .req_compl_with_data_i(req_compl_with_data_i),
        .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i),
        .req_attr_i(req_attr_i), .req_len_i(req_len_i), .req_rid_i(req_rid_i),
        .req_tag_i(req_tag_i), .req_be_i(req_be_i), .req_addr_i(req_addr_i),
        .flush_i(flush_i), .rx_np_ok_o(rx_np_ok), .req_compl_o(req_compl),
        .req_compl_with_data_o(wd), .req_tc_o(tc), .req_td_o(td), .req_ep_o(ep),
        .req_attr_o(attr), .req_len_o(len), .req_rid_o(rid), .req_tag_o(tag),
        .req_be_o(be), .req_addr_o(addr), .compl_done_i(compl_done_i),
        .compl_done_o(compl_done), .count_o(count), .ovf_o(ovf), .timeout_o(tmo)
    );

    np_cpl_queue #(.TIMEOUT_CYC(8)) u_dut_to (
        .clk(clk), .rst(rst),
        .req_compl_i(req_compl_i), .req_compl_with_data_i(req_compl_with_data_i),
        .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i),
        .req_attr_i(req_attr_i), .req_len_i(req_len_i), .req_rid_i(req_rid_i),
        .req_tag_i(req_tag_i), .req_be_i(req_be_i), .req_addr_i(req_addr_i),
        .flush_i(flush_i), .rx_np_ok_o(to_rx_np_ok), .req_compl_o(to_req_compl),
        .req_compl_with_data_o(to_wd), .req_tc_o(to_tc), .req_td_o(to_td), .req_ep_o(to_ep),
        .req_attr_o(to_attr), .req_len_o(to_len), .req_rid_o(to_rid), .req_tag_o(to_tag),
        .req_be_o(to_be), .req_addr_o(to_addr), .compl_done_i(compl_done_i),
        .compl_done_o(to_compl_done), .count_o(to_count), .ovf_o(to_ovf), .timeout_o(to_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
        end
    endtask

    // One-cycle enqueue pulse; back-to-back calls hit consecutive edges.
    task automatic enq(input logic [7:0] t, input logic [ADDR_W-1:0] a, input logic w);
        req_compl_i           = 1'b1;
        req_compl_with_data_i = w;
        req_tag_i             = t;
        req_addr_i            = a;
        tick();
        req_compl_i = 1'b0;
    endtask

    // Bounded wait for u_dut to present a request, then check its tag.
    task automatic wait_issue(input logic [7:0] t);
        int k = 0;
        while (req_compl !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("issue_valid", 32'(req_compl), 32'd1);
        chk("issue_tag", 32'(tag), 32'(t));
    endtask

    task automatic retire();
        compl_done_i = 1'b1;
        tick();
        compl_done_i = 1'b0;
        chk("retire_pulse", 32'(compl_done), 32'd1);
        chk("retire_drop", 32'(req_compl), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_compl_i = 1'b0; req_compl_with_data_i = 1'b0;
        req_tc_i = 3'd2; req_td_i = 1'b0; req_ep_i = 1'b0; req_attr_i = 2'd1;
        req_len_i = 10'd1; req_rid_i = 16'hBEEF; req_tag_i = 8'h00; req_be_i = 8'h0F;
        req_addr_i = '0; flush_i = 1'b0; compl_done_i = 1'b0;
        tick();
        tick();
        chk("rst_req_compl", 32'(req_compl), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_timeout", 32'(tmo), 32'd0);
        chk("rst_np_ok", 32'(rx_np_ok), 32'd1);
        chk("rst_tag", 32'(tag), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single request, 2-cycle latency, fields, retire
        enq(8'h5A, 13'h123, 1'b1);
        chk("t1_count_after_enq", 32'(count), 32'd1);
        chk("t1_not_yet", 32'(req_compl), 32'd0);
        tick();
        chk("t1_load_count", 32'(count), 32'd0);
        chk("t1_load_not_yet", 32'(req_compl), 32'd0);
        tick();
        chk("t1_req_compl", 32'(req_compl), 32'd1);
        chk("t1_tag", 32'(tag), 32'h5A);
        chk("t1_addr", 32'(addr), 32'h123);
        chk("t1_len", 32'(len), 32'd1);
        chk("t1_with_data", 32'(wd), 32'd1);
        chk("t1_rid", 32'(rid), 32'hBEEF);
        chk("t1_be", 32'(be), 32'h0F);
        chk("t1_tc", 32'(tc), 32'd2);
        chk("t1_attr", 32'(attr), 32'd1);
        tick();
        chk("t1_hold", 32'(req_compl), 32'd1);
        retire();
        tick();
        chk("t1_pulse_once", 32'(compl_done), 32'd0);
        chk("t1_count_end", 32'(count), 32'd0);

        // 2: fill to full with the head in ISSUE; 18th enqueue is dropped
        for (int i = 0; i < 18; i++) begin
            enq(8'(i), 13'(i), 1'b0);
            if (i == 1)  chk("t2_count_i1", 32'(count), 32'd1);
            if (i == 13) begin
                chk("t2_count_i13", 32'(count), 32'd13);
                chk("t2_np_ok_i13", 32'(rx_np_ok), 32'd1);
            end
            if (i == 14) begin
                chk("t2_count_i14", 32'(count), 32'd14);
                chk("t2_np_ok_i14", 32'(rx_np_ok), 32'd0);
            end
            if (i == 16) begin
                chk("t2_count_full", 32'(count), 32'd16);
                chk("t2_ovf_before", 32'(ovf), 32'd0);
            end
        end
        chk("t2_count_kept", 32'(count), 32'd16);
        chk("t2_ovf", 32'(ovf), 32'd1);
        chk("t2_head_tag", 32'(tag), 32'd0);
        for (int t = 0; t < 17; t++) begin
            wait_issue(8'(t));
            retire();
        end
        tick();
        tick();
        chk("t2_count_end", 32'(count), 32'd0);
        chk("t2_np_ok_end", 32'(rx_np_ok), 32'd1);
        chk("t2_ovf_sticky", 32'(ovf), 32'd1);

        // 3: enqueue coinciding with an IDLE pop at count 5
        for (int i = 0; i < 6; i++) enq(8'(8'h20 + i), 13'(i), 1'b1);
        chk("t3_count5", 32'(count), 32'd5);
        chk("t3_head", 32'(tag), 32'h20);
        retire();
        chk("t3_count_after_retire", 32'(count), 32'd5);
        enq(8'h26, 13'h6, 1'b1);
        chk("t3_count_same", 32'(count), 32'd5);
        for (int t = 8'h21; t <= 8'h26; t++) begin
            wait_issue(8'(t));
            retire();
        end
        tick();
        chk("t3_count_end", 32'(count), 32'd0);

        // 4: timeout instance retires after 8 ISSUE cycles, then issues next
        do_reset();
        enq(8'h40, 13'h40, 1'b0);
        enq(8'h41, 13'h41, 1'b0);
        tick();
        chk("t4_issue", 32'(to_req_compl), 32'd1);
        chk("t4_issue_tag", 32'(to_tag), 32'h40);
        repeat (7) tick();
        chk("t4_still_issue", 32'(to_req_compl), 32'd1);
        chk("t4_no_timeout_yet", 32'(to_tmo), 32'd0);
        tick();
        chk("t4_dropped", 32'(to_req_compl), 32'd0);
        chk("t4_done_pulse", 32'(to_compl_done), 32'd1);
        chk("t4_timeout", 32'(to_tmo), 32'd1);
        chk("t4_no_timeout_dut", 32'(tmo), 32'd0);
        tick();
        tick();
        chk("t4_next_issue", 32'(to_req_compl), 32'd1);
        chk("t4_next_tag", 32'(to_tag), 32'h41);
        chk("t4_count", 32'(to_count), 32'd0);

        // 5: flush during ISSUE with 4 queued; same-cycle enqueue discarded
        do_reset();
        for (int i = 0; i < 5; i++) enq(8'(8'h50 + i), 13'(i), 1'b0);
        chk("t5_count4", 32'(count), 32'd4);
        chk("t5_head", 32'(tag), 32'h50);
        flush_i     = 1'b1;
        req_compl_i = 1'b1;
        req_tag_i   = 8'h55;
        tick();
        flush_i     = 1'b0;
        req_compl_i = 1'b0;
        chk("t5_count_flushed", 32'(count), 32'd0);
        chk("t5_current_kept", 32'(req_compl), 32'd1);
        chk("t5_current_tag", 32'(tag), 32'h50);
        retire();
        repeat (5) tick();
        chk("t5_no_more", 32'(req_compl), 32'd0);
        chk("t5_count_end", 32'(count), 32'd0);
        chk("t5_np_ok", 32'(rx_np_ok), 32'd1);
        chk("t5_ovf", 32'(ovf), 32'd0);

        // 6: asynchronous reset in the middle of ISSUE
        do_reset();
        for (int i = 0; i < 3; i++) enq(8'(8'h60 + i), 13'(i), 1'b1);
        repeat (8) tick();
        chk("t6_pre_issue", 32'(req_compl), 32'd1);
        chk("t6_pre_count", 32'(count), 32'd2);
        chk("t6_pre_timeout", 32'(to_tmo), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_compl", 32'(req_compl), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_ovf", 32'(ovf), 32'd0);
        chk("t6_timeout", 32'(to_tmo), 32'd0);
        chk("t6_to_req_compl", 32'(to_req_compl), 32'd0);
        chk("t6_tag", 32'(tag), 32'd0);
        chk("t6_np_ok", 32'(rx_np_ok), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
